zbt_arbiter: RTL and testbench

- Two-port arbiter in front of the ZBT driver. It shares one ZBT SRAM bank between a high-priority read-only port A (video/display fetch) and a read/write port B (sample or frame-buffer writer).
- Issues at most one access per clock. Tracks the driver's two-cycle pipeline so read data returns to the requester that issued it.
- Bounds port-B starvation with a wait counter.

---
 rtl/zbt_arbiter.sv | 120 ++++++++++++
 tb/tb_zbt_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/zbt_arbiter.sv
// zbt_arbiter
// Shares one ZBT SRAM bank between a high-priority read-only port A and a
// read/write port B. Issues at most one access per clock and tracks the
// driver's two-cycle read pipeline so read data returns to its requester.
// A wait counter bounds how long port B can be held off by port A.
//
// Ports:
//   clk, reset               system clock, synchronous active-high reset
//   a_req/a_addr             port A read request and address
//   a_ack                    port A granted this cycle (combinational)
//   a_rdata/a_rvalid         port A registered read data and one-cycle valid
//   b_req/b_we/b_addr/b_wdata port B request, write enable, address, data
//   b_ack                    port B granted this cycle (combinational)
//   b_rdata/b_rvalid         port B registered read data and one-cycle valid
//   z_cen/z_we/z_addr/z_wdata to the ZBT driver
//   z_rdata                  read data from the ZBT driver
module zbt_arbiter #(
  parameter int AW         = 19,
  parameter int DW         = 36,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          b_rvalid,
  output logic          z_cen,
  output logic          z_we,
  output logic [AW-1:0] z_addr,
  output logic [DW-1:0] z_wdata,
  input  logic [DW-1:0] z_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt;
  logic [AW-1:0] held_addr;
  logic          rd_v0, rd_s0, rd_v1, rd_s1;
  logic          b_win, a_win;

  // B only overtakes A once it has been denied STARVE_MAX cycles in a row.
  assign b_win = !reset && b_req && (!a_req || starve_cnt == STARVE_LIM);
  assign a_win = !reset && a_req && !b_win;

  assign a_ack = a_win;
  assign b_ack = b_win;

  // The driver pipeline must never stall, so chip enable is tied on.
  // Idle cycles repeat the last granted address as a harmless dummy read.
  assign z_cen = 1'b1;

  always_comb begin
    z_we    = 1'b0;
    z_addr  = held_addr;
    z_wdata = '0;
    if (reset) begin
      z_addr = '0;
    end else if (b_win) begin
      z_we    = b_we;
      z_addr  = b_addr;
      z_wdata = b_wdata;
    end else if (a_win) begin
      z_addr = a_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      held_addr  <= '0;
      rd_v0      <= 1'b0;
      rd_s0      <= 1'b0;
      rd_v1      <= 1'b0;
      rd_s1      <= 1'b0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
    end else begin
      if (!b_req || b_win) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      if (b_win) begin
        held_addr <= b_addr;
      end else if (a_win) begin
        held_addr <= a_addr;
      end

      // {valid, src} tracks each read through the driver's two-stage
      // pipeline; src=1 marks a port B read.
      rd_v0 <= a_win || (b_win && !b_we);
      rd_s0 <= b_win;
      rd_v1 <= rd_v0;
      rd_s1 <= rd_s0;

      a_rvalid <= rd_v1 && !rd_s1;
      b_rvalid <= rd_v1 && rd_s1;
      if (rd_v1 && !rd_s1) begin
        a_rdata <= z_rdata;
      end
      if (rd_v1 && rd_s1) begin
        b_rdata <= z_rdata;
      end
    end
  end

endmodule

// File: tb/tb_zbt_arbiter.sv
module tb_zbt_arbiter;
  localparam int AW = 19;
  localparam int DW = 36;
  localparam int SM = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr, z_addr;
  logic [DW-1:0] b_wdata, a_rdata, b_rdata, z_wdata, z_rdata;
  logic          a_ack, b_ack, a_rvalid, b_rvalid, z_cen, z_we;

  zbt_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack),
    .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .z_cen(z_cen), .z_we(z_we), .z_addr(z_addr), .z_wdata(z_wdata), .z_rdata(z_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ZBT driver + RAM model: an access presented in cycle N returns read data
  // during cycle N+2; writes land in the RAM at the end of cycle N+2.
  logic [DW-1:0] mem [0:1023];
  bit            mem_init = 1'b0;
  logic          d0_we, d1_we;
  logic [AW-1:0] d0_addr, d1_addr;
  logic [DW-1:0] d0_wd, d1_wd;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      mem[10'h010] = 36'h123456789;
      mem[10'h100] = 36'h111111111;
      mem[10'h200] = 36'h222222222;
      mem[10'h300] = 36'h333333333;
      mem_init = 1'b1;
    end else if (d1_we) begin
      mem[d1_addr[9:0]] = d1_wd;
    end
    d0_we   <= z_we;
    d0_addr <= z_addr;
    d0_wd   <= z_wdata;
    d1_we   <= d0_we;
    d1_addr <= d0_addr;
    d1_wd   <= d0_wd;
  end

  assign z_rdata = mem[d1_addr[9:0]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard: expected read returns are pushed when a read is acked.
  typedef struct packed {
    logic          src;
    logic [DW-1:0] data;
    logic [31:0]   cyc;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] exp_a = '0;
  logic [DW-1:0] exp_b = '0;

  always @(negedge clk) begin
    if (a_rvalid || b_rvalid) begin
      check("rvalid_excl", 64'(a_rvalid & b_rvalid), 64'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rvalid: a_rvalid=%0b b_rvalid=%0b with no read outstanding (cycle %0d)",
                 a_rvalid, b_rvalid, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("rvalid_port", 64'(b_rvalid), 64'(mon_e.src));
        check("rdata", 64'(mon_e.src ? b_rdata : a_rdata), 64'(mon_e.data));
        check("read_latency", 64'(cyc), 64'(mon_e.cyc + 32'd3));
      end
    end
    // Reads still in flight at reset never return.
    if (reset) begin
      sb.delete();
    end else begin
      if (a_ack) sb.push_back('{1'b0, exp_a, 32'(cyc)});
      if (b_ack && !b_we) sb.push_back('{1'b1, exp_b, 32'(cyc)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic grants(input string name, input logic ea, input logic eb);
    @(negedge clk);
    check(name, 64'({a_ack, b_ack}), 64'({ea, eb}));
  endtask

  task automatic idle(input int n);
    a_req = 1'b0;
    b_req = 1'b0;
    b_we  = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    a_req   = 1'b1;
    b_req   = 1'b1;
    b_we    = 1'b1;
    a_addr  = 19'h00abc;
    b_addr  = 19'h00def;
    b_wdata = 36'hfffffffff;

    // Reset: no grants despite requests, driver outputs quiet.
    grants("reset_acks", 1'b0, 1'b0);
    check("reset_z_cen", 64'(z_cen), 64'd1);
    check("reset_z_we", 64'(z_we), 64'd0);
    check("reset_z_addr", 64'(z_addr), 64'd0);
    step();
    @(negedge clk);
    check("reset_rvalid", 64'({a_rvalid, b_rvalid}), 64'd0);
    check("reset_rdata", 64'({a_rdata, b_rdata}), 64'd0);
    step();
    reset = 1'b0;
    idle(3);

    // A read of 0x00010.
    a_req = 1'b1; a_addr = 19'h00010; exp_a = 36'h123456789;
    grants("a_read_ack", 1'b1, 1'b0);
    check("a_read_z_addr", 64'(z_addr), 64'h10);
    check("a_read_z_we", 64'(z_we), 64'd0);
    step();
    idle(6);
    @(negedge clk);
    check("a_rdata_hold", 64'(a_rdata), 64'h123456789);
    step();

    // B write 0x7FFFF, then B read back.
    b_req = 1'b1; b_we = 1'b1; b_addr = 19'h7ffff; b_wdata = 36'habcde0123;
    grants("b_write_ack", 1'b0, 1'b1);
    check("b_write_z", 64'({z_we, z_addr}), 64'({1'b1, 19'h7ffff}));
    check("b_write_z_wdata", 64'(z_wdata), 64'habcde0123);
    step();
    b_we = 1'b0; exp_b = 36'habcde0123;
    grants("b_read_ack", 1'b0, 1'b1);
    step();
    idle(6);

    // Idle after a write to 0x00055: dummy reads at the held address.
    b_req = 1'b1; b_we = 1'b1; b_addr = 19'h00055; b_wdata = 36'h555555555;
    grants("idle_wr_ack", 1'b0, 1'b1);
    step();
    b_req = 1'b0; b_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_state", 64'({a_ack, b_ack, z_we, z_cen, z_addr}), 64'({4'b0001, 19'h00055}));
      check("idle_z_wdata", 64'(z_wdata), 64'd0);
      step();
    end

    // Starvation: both ports held, grants follow A x8, B x1.
    a_req = 1'b1; a_addr = 19'h00100; exp_a = 36'h111111111;
    b_req = 1'b1; b_we = 1'b0; b_addr = 19'h00200; exp_b = 36'h222222222;
    for (int i = 0; i < 27; i++) begin
      grants("starve_pattern", ((i % 9) != 8), ((i % 9) == 8));
      step();
    end
    idle(6);

    // Interleaved: A 0x100 (8th A grant), B 0x200 (forced), A 0x300.
    a_req = 1'b1; a_addr = 19'h00100; exp_a = 36'h111111111;
    b_req = 1'b1; b_we = 1'b0; b_addr = 19'h00200; exp_b = 36'h222222222;
    for (int i = 0; i < 8; i++) begin
      grants("inter_a_first", 1'b1, 1'b0);
      step();
    end
    grants("inter_b_forced", 1'b0, 1'b1);
    step();
    b_req = 1'b0; a_addr = 19'h00300; exp_a = 36'h333333333;
    grants("inter_a_last", 1'b1, 1'b0);
    check("inter_a_last_addr", 64'(z_addr), 64'h300);
    step();
    idle(6);

    // Reset mid-flight: granted A read must never return.
    a_req = 1'b1; a_addr = 19'h00010; exp_a = 36'h123456789;
    grants("rst_pre_ack", 1'b1, 1'b0);
    step();
    reset = 1'b1;
    b_req = 1'b1; b_we = 1'b1; b_addr = 19'h01234; b_wdata = 36'hfffffffff;
    grants("rst_mid_acks", 1'b0, 1'b0);
    check("rst_mid_z", 64'({z_cen, z_we, z_addr}), 64'({2'b10, 19'h0}));
    check("rst_mid_z_wdata", 64'(z_wdata), 64'd0);
    step();
    reset = 1'b0;
    a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
    @(negedge clk);
    check("rst_post_out", 64'({a_rvalid, b_rvalid, a_ack, b_ack}), 64'd0);
    check("rst_post_rdata", 64'({a_rdata, b_rdata}), 64'd0);
    step();
    @(negedge clk);
    check("rst_no_rvalid", 64'({a_rvalid, b_rvalid}), 64'd0);
    step();
    idle(2);

    // Normal request after reset.
    a_req = 1'b1; a_addr = 19'h00010; exp_a = 36'h123456789;
    grants("post_rst_ack", 1'b1, 1'b0);
    step();
    idle(6);

    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
